// File: rtl/crc_sig_pkg.sv
// crc_sig_pkg: shared FSM encoding, default seed/taps and the LFSR step function.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package crc_sig_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [63:0] DEFAULT_SEED = 64'h5aef0c8d_d70a4497;
    localparam logic [63:0] DEFAULT_TAPS = 64'h8000_0000_0000_0005;

    // One shift of a width-bit LFSR held in the low bits of a 64-bit word.
    // Feedback is the parity of the current value masked by taps.
    function automatic logic [63:0] lfsr_next(input logic [63:0] cur,
                                              input logic [63:0] taps,
                                              input int          width);
        logic [63:0] mask;
        logic        fb;
        mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        fb   = ^(cur & taps & mask);
        return ((cur << 1) | {63'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/crc_sig_lfsr.sv
// crc_sig_lfsr: one LFSR register; clr loads INIT, en shifts and folds din in.
// Latency: 1 cycle from clr/en to q.
// Backpressure: none; en low holds the register.
module crc_sig_lfsr
    import crc_sig_pkg::*;
#(
    parameter int          WIDTH = 64,
    parameter logic [63:0] TAPS  = DEFAULT_TAPS,
    parameter logic [63:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q
);

    logic [63:0] q_ext;
    logic [63:0] nxt;

    assign q_ext = 64'(q);
    assign nxt   = lfsr_next(q_ext, TAPS, WIDTH);

    // clr wins over en so a warm-up or restart load is never lost to a shift.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= INIT[WIDTH-1:0];
        else if (en)
            q <= nxt[WIDTH-1:0] ^ din;
    end

endmodule

// File: rtl/crc_sig_harness.sv
// crc_sig_harness: CRC stimulus generator plus per-channel signatures, checked after RUN_CYC steps.
// Latency: done_o rises RUN_CYC+1 edges after start is accepted, plus any cycles spent in hold.
// Backpressure: hold_i freezes cyc/crc/signatures in RUN; start_i is ignored while busy.
// Optional CRC_SIG_FIRST_FAIL_EN: adds first_fail_o/first_fail_vld_o and a hold-entry trace.
module crc_sig_harness
    import crc_sig_pkg::*;
#(
    parameter int          CRC_W      = 64,
    parameter int          RES_W      = 64,
    parameter int          NCHAN      = 1,
    parameter logic [63:0] SEED       = DEFAULT_SEED,
    parameter logic [63:0] TAPS       = DEFAULT_TAPS,
    parameter int          WARMUP_CYC = 10,
    parameter int          RUN_CYC    = 99
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   hold_i,
    input  logic [NCHAN*RES_W-1:0] result_i,
    input  logic [CRC_W-1:0]       exp_crc_i,
    input  logic [NCHAN*RES_W-1:0] exp_sum_i,
    output logic [CRC_W-1:0]       stim_o,
    output logic [15:0]            cyc_o,
    output logic [NCHAN*RES_W-1:0] sum_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [NCHAN:0]         fail_mask_o
`ifdef CRC_SIG_FIRST_FAIL_EN
    ,
    output logic [$clog2(NCHAN+1)-1:0] first_fail_o,
    output logic                       first_fail_vld_o
`endif
);

    generate
        if (RUN_CYC >= 65535) begin : g_chk_run_cyc
            $error("crc_sig_harness: RUN_CYC must be < 65535");
        end
        if (RUN_CYC <= WARMUP_CYC) begin : g_chk_warmup
            $error("crc_sig_harness: RUN_CYC must exceed WARMUP_CYC");
        end
        if (NCHAN < 1 || NCHAN > 16) begin : g_chk_nchan
            $error("crc_sig_harness: NCHAN must be 1..16");
        end
        if (CRC_W < 8 || CRC_W > 64 || RES_W < 8 || RES_W > 64) begin : g_chk_width
            $error("crc_sig_harness: CRC_W and RES_W must be 8..64");
        end
    endgenerate

    state_t                   state_q, state_d;
    logic [15:0]              cyc_q;
    logic [CRC_W-1:0]         crc_q;
    logic [NCHAN*RES_W-1:0]   sum_q;
    logic [NCHAN:0]           mismatch;
    logic                     accept;
    logic                     step;
    logic                     last_step;
    logic                     warm;

    assign accept    = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign step      = (state_q == ST_RUN) && !hold_i;
    assign last_step = step && (cyc_q == 16'(RUN_CYC - 1));
    assign warm      = (cyc_q < 16'(WARMUP_CYC));

    assign stim_o = crc_q;
    assign cyc_o  = cyc_q;
    assign sum_o  = sum_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next state and busy flag; CHECK always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
                busy_o = 1'b1;
                if (last_step) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                busy_o  = 1'b1;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run cycle counter, restarts on accept and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            cyc_q <= '0;
        else if (accept)
            cyc_q <= '0;
        else if (step && cyc_q != 16'hFFFF)
            cyc_q <= cyc_q + 16'd1;
    end

    crc_sig_lfsr #(
        .WIDTH (CRC_W),
        .TAPS  (TAPS),
        .INIT  (SEED)
    ) u_stim (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (step),
        .din ('0),
        .q   (crc_q)
    );

    // Signatures are forced to zero through the warm-up window via the clear path.
    for (genvar c = 0; c < NCHAN; c++) begin : g_sig
        crc_sig_lfsr #(
            .WIDTH (RES_W),
            .TAPS  (TAPS),
            .INIT  ('0)
        ) u_sig (
            .clk (clk),
            .rst (rst),
            .clr (accept || (step && warm)),
            .en  (step),
            .din (result_i[c*RES_W +: RES_W]),
            .q   (sum_q[c*RES_W +: RES_W])
        );
    end

    // Full-width compare of CRC and every signature against the expected values.
    always_comb begin
        mismatch        = '0;
        mismatch[NCHAN] = (crc_q != exp_crc_i);
        for (int c = 0; c < NCHAN; c++)
            mismatch[c] = (sum_q[c*RES_W +: RES_W] != exp_sum_i[c*RES_W +: RES_W]);
    end

    // Verdict registers: cleared on restart, captured on the edge leaving CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_mask_o <= '0;
            pass_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (accept) begin
            fail_mask_o <= '0;
            pass_o      <= 1'b0;
            done_o      <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            fail_mask_o <= mismatch;
            pass_o      <= ~|mismatch;
            done_o      <= 1'b1;
        end
    end

`ifdef CRC_SIG_FIRST_FAIL_EN
    localparam int FF_W = $clog2(NCHAN + 1);
    logic [FF_W-1:0] first_idx;

    // Lowest set mismatch index: scan downwards so the smallest one wins.
    always_comb begin
        first_idx = '0;
        for (int i = NCHAN; i >= 0; i--)
            if (mismatch[i]) first_idx = FF_W'(i);
    end

    // First-fail capture alongside the main verdict.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            first_fail_o     <= '0;
            first_fail_vld_o <= 1'b0;
        end else if (state_q == ST_CHECK) begin
            first_fail_o     <= first_idx;
            first_fail_vld_o <= |mismatch;
        end
    end

`ifdef TEST_VERBOSE
    logic hold_q;

    // Previous hold level, so the trace fires once per stall.
    always_ff @(posedge clk) begin
        if (rst)
            hold_q <= 1'b0;
        else
            hold_q <= hold_i;
    end

    // Debug trace on stall entry.
    always @(posedge clk) begin
        if (!rst && hold_i && !hold_q)
            $display("[%0t] crc_sig_harness: hold rises cyc=%0d crc=%h", $time, cyc_q, crc_q);
    end
`endif
`endif

endmodule

// File: tb/tb_crc_sig_harness.sv
// tb_crc_sig_harness: directed runs with random channel data against a run-level reference model.
// Latency: checks done_o timing of RUN_CYC+1 edges after accept plus hold cycles.
// Backpressure: exercises hold_i stalls, ignored start in RUN, restart from DONE and mid-run reset.
module tb_crc_sig_harness;

    localparam int          CRC_W      = 64;
    localparam int          RES_W      = 64;
    localparam int          NCHAN      = 4;
    localparam int          WARMUP_CYC = 10;
    localparam int          RUN_CYC    = 99;
    localparam logic [63:0] SEED       = 64'h5aef0c8d_d70a4497;
    localparam logic [63:0] TAPS       = 64'h8000_0000_0000_0005;
    localparam int          FF_W       = $clog2(NCHAN + 1);

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start_i;
    logic                   hold_i;
    logic [NCHAN*RES_W-1:0] result_i;
    logic [CRC_W-1:0]       exp_crc_i;
    logic [NCHAN*RES_W-1:0] exp_sum_i;
    logic [CRC_W-1:0]       stim_o;
    logic [15:0]            cyc_o;
    logic [NCHAN*RES_W-1:0] sum_o;
    logic                   busy_o;
    logic                   done_o;
    logic                   pass_o;
    logic [NCHAN:0]         fail_mask_o;
`ifdef CRC_SIG_FIRST_FAIL_EN
    logic [FF_W-1:0]        first_fail_o;
    logic                   first_fail_vld_o;
`endif

    // Reference state: CRC trajectory, per-step channel data, expected final values.
    logic [63:0] stim_seq [RUN_CYC+1];
    logic [63:0] res_tbl  [RUN_CYC][NCHAN];
    logic [63:0] m_sum    [NCHAN];
    logic [63:0] m_crc;
    int          ncmp = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    crc_sig_harness #(
        .CRC_W      (CRC_W),
        .RES_W      (RES_W),
        .NCHAN      (NCHAN),
        .SEED       (SEED),
        .TAPS       (TAPS),
        .WARMUP_CYC (WARMUP_CYC),
        .RUN_CYC    (RUN_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .hold_i      (hold_i),
        .result_i    (result_i),
        .exp_crc_i   (exp_crc_i),
        .exp_sum_i   (exp_sum_i),
        .stim_o      (stim_o),
        .cyc_o       (cyc_o),
        .sum_o       (sum_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_mask_o (fail_mask_o)
`ifdef CRC_SIG_FIRST_FAIL_EN
        ,
        .first_fail_o     (first_fail_o),
        .first_fail_vld_o (first_fail_vld_o)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] shift_fb(input logic [63:0] v);
        return {v[62:0], ^(v & TAPS)};
    endfunction

    // stim_seq[k] is the stimulus seen while the run is at cycle k.
    task automatic build_stim_seq();
        stim_seq[0] = SEED;
        for (int k = 0; k < RUN_CYC; k++)
            stim_seq[k+1] = shift_fb(stim_seq[k]);
    endtask

    // Final CRC is RUN_CYC shifts from the seed; each signature folds one word per step after warm-up.
    task automatic run_model();
        logic [63:0] s;
        m_crc = stim_seq[RUN_CYC];
        for (int c = 0; c < NCHAN; c++) begin
            s = '0;
            for (int k = 0; k < RUN_CYC; k++)
                s = (k < WARMUP_CYC) ? 64'd0 : (res_tbl[k][c] ^ shift_fb(s));
            m_sum[c] = s;
        end
    endtask

    function automatic logic [NCHAN*RES_W-1:0] pack_res(input int k);
        logic [NCHAN*RES_W-1:0] p;
        for (int c = 0; c < NCHAN; c++) p[c*RES_W +: RES_W] = res_tbl[k][c];
        return p;
    endfunction

    function automatic logic [NCHAN*RES_W-1:0] pack_sum();
        logic [NCHAN*RES_W-1:0] p;
        for (int c = 0; c < NCHAN; c++) p[c*RES_W +: RES_W] = m_sum[c];
        return p;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " stim"}, stim_o, '0);
        check({tag, " cyc"}, cyc_o, '0);
        check({tag, " sum"}, sum_o, '0);
        check({tag, " busy/done/pass/mask"}, {busy_o, done_o, pass_o, fail_mask_o}, '0);
    endtask

    // One complete run from a start pulse. Negative step indices disable the optional events.
    task automatic do_run(input int hold_at, input int hold_len, input int rst_at,
                          input int corrupt_k, input int corrupt_ch, input int start_at,
                          input logic [NCHAN:0] exp_mask, input string tag);
        logic [NCHAN*RES_W-1:0] r;
        int n;
        int ff;
        n = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check({tag, " accept busy"}, busy_o, 1'b1);
        check({tag, " accept done clear"}, done_o, 1'b0);
        check({tag, " accept cyc"}, cyc_o, '0);
        for (int k = 0; k < RUN_CYC; k++) begin
            r = pack_res(k);
            if (k == corrupt_k) r[corrupt_ch*RES_W +: RES_W] = r[corrupt_ch*RES_W +: RES_W] ^ 64'h1;
            result_i = r;
            if (k == hold_at) begin
                hold_i = 1'b1;
                repeat (hold_len) begin
                    tick();
                    n++;
                end
                hold_i = 1'b0;
                check({tag, " hold cyc"}, cyc_o, k);
                check({tag, " hold stim"}, stim_o, stim_seq[k]);
            end
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_all_zero({tag, " midrun rst"});
                return;
            end
            if (k == start_at) start_i = 1'b1;
            tick();
            n++;
            start_i = 1'b0;
            if (k == start_at) check({tag, " start in run cyc"}, cyc_o, k + 1);
        end
        check({tag, " check busy"}, busy_o, 1'b1);
        check({tag, " check cyc"}, cyc_o, RUN_CYC);
        check({tag, " check done low"}, done_o, 1'b0);
        check({tag, " final stim"}, stim_o, m_crc);
        if (corrupt_k < 0) check({tag, " final sum"}, sum_o, pack_sum());
        tick();
        n++;
        check({tag, " done"}, done_o, 1'b1);
        check({tag, " idle busy"}, busy_o, 1'b0);
        check({tag, " done latency"}, n, RUN_CYC + 1 + hold_len);
        check({tag, " pass"}, pass_o, (exp_mask == '0));
        check({tag, " mask"}, fail_mask_o, exp_mask);
        ff = 0;
        for (int i = NCHAN; i >= 0; i--) if (exp_mask[i]) ff = i;
`ifdef CRC_SIG_FIRST_FAIL_EN
        check({tag, " first_fail_vld"}, first_fail_vld_o, |exp_mask);
        check({tag, " first_fail"}, first_fail_o, FF_W'(ff));
`endif
    endtask

    task automatic load_expect();
        run_model();
        exp_crc_i = m_crc;
        exp_sum_i = pack_sum();
    endtask

    initial begin
        rst       = 1'b1;
        start_i   = 1'b0;
        hold_i    = 1'b0;
        result_i  = '0;
        exp_crc_i = '0;
        exp_sum_i = '0;
        tick();
        tick();
        rst = 1'b0;
        check_all_zero("reset");

        build_stim_seq();

        // All-zero results: signatures stay zero, CRC follows the seed trajectory.
        for (int k = 0; k < RUN_CYC; k++)
            for (int c = 0; c < NCHAN; c++) res_tbl[k][c] = '0;
        load_expect();
        do_run(-1, 0, -1, -1, 0, -1, '0, "zero");
        check("zero sum literal", sum_o, '0);

        // Channel 0 folds stim[0], other channels random words.
        for (int k = 0; k < RUN_CYC; k++) begin
            res_tbl[k][0] = {63'd0, stim_seq[k][0]};
            for (int c = 1; c < NCHAN; c++) res_tbl[k][c] = {$urandom(), $urandom()};
        end
        load_expect();
        do_run(-1, 0, -1, -1, 0, -1, '0, "rand");

        // One expected bit flipped on channel 0; restart from DONE.
        exp_sum_i[0] = ~exp_sum_i[0];
        do_run(-1, 0, -1, -1, 0, -1, 5'b00001, "flip0");
        exp_sum_i[0] = ~exp_sum_i[0];

        // Channel 2 data corrupted at cycle 50.
        do_run(-1, 0, -1, 50, 2, -1, 5'b00100, "corrupt2");

        // CRC and channel 1 expectations both wrong.
        exp_crc_i[63]      = ~exp_crc_i[63];
        exp_sum_i[RES_W+5] = ~exp_sum_i[RES_W+5];
        do_run(-1, 0, -1, -1, 0, -1, 5'b10010, "crc+ch1");
        exp_crc_i[63]      = ~exp_crc_i[63];
        exp_sum_i[RES_W+5] = ~exp_sum_i[RES_W+5];

        // Seven-cycle stall at cycle 30 with zero data.
        for (int k = 0; k < RUN_CYC; k++)
            for (int c = 0; c < NCHAN; c++) res_tbl[k][c] = '0;
        load_expect();
        do_run(30, 7, -1, -1, 0, -1, '0, "hold");

        // Reset mid-run, then a clean rerun.
        do_run(-1, 0, 60, -1, 0, -1, '0, "rst60");
        do_run(-1, 0, -1, -1, 0, -1, '0, "rerun");

        // Start pulse while running is ignored.
        for (int k = 0; k < RUN_CYC; k++)
            for (int c = 0; c < NCHAN; c++) res_tbl[k][c] = {$urandom(), $urandom()};
        load_expect();
        do_run(-1, 0, -1, -1, 0, 20, '0, "start20");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
